// File: rtl/icdf_pkg.sv
// Shared widths and state encoding for the ICDF URNG decoder.
package icdf_pkg;

  localparam int SEG_W  = 6;
  localparam int URNG_W = 64;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_WARMUP = 2'd1;
  localparam logic [1:0] ENC_RUN    = 2'd2;
  localparam logic [1:0] ENC_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ENC_IDLE,
    ST_WARMUP = ENC_WARMUP,
    ST_RUN    = ENC_RUN,
    ST_DRAIN  = ENC_DRAIN
  } state_e;

endpackage

// File: rtl/lzc63.sv
// Leading-zero counter over a 63-bit magnitude; an all-zero input reports 63.
module lzc63 (
  input  logic [62:0] din,
  output logic [5:0]  lz
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    lz = 6'd63;
    for (int i = 0; i <= 62; i++) begin
      if (din[i]) lz = 6'(62 - i);
    end
  end

endmodule

// File: rtl/icdf_urng_decoder.sv
// Consumer-side controller for the 64-bit Tausworthe URNG: sequences the
// generator enable, discards warm-up output, decodes each captured word into
// sign / segment index / segment offset and queues results for the lookup stage.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | generator held in reseed (en_taus=0), waiting for start
// WARMUP | generator running, output discarded until warm-up completes
// RUN    | generator running, one word captured per cycle
// DRAIN  | generator stopped, in-flight words flushed to the consumer
module icdf_urng_decoder
  import icdf_pkg::*;
#(
  parameter int WARMUP  = 8,
  parameter int MAX_SEG = 62,
  parameter int OFF_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en_taus,
  input  logic [URNG_W-1:0] taus_in,
  output logic              seg_valid,
  input  logic              seg_ready,
  output logic              seg_sign,
  output logic [SEG_W-1:0]  seg_idx,
  output logic [OFF_W-1:0]  seg_off,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  // The RUN state is entered one edge early so that the first RUN-edge
  // sample lands on the WARMUP-th edge after en_taus rises (needs WARMUP >= 2).
  localparam int               CNT_W   = ($clog2(WARMUP) > 0) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0] WU_LAST = CNT_W'(WARMUP - 2);
  localparam int               AW      = $clog2(DEPTH);
  localparam int               PTR_W   = AW + 1;
  localparam int               ENT_W   = 1 + SEG_W + OFF_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wu_cnt_q, wu_cnt_d;
  logic             en_taus_q, en_taus_d;
  logic             busy_q, busy_d;

  logic              s1_v_q, s1_v_d;
  logic [URNG_W-1:0] s1_w_q, s1_w_d;
  logic              s2_v_q, s2_v_d;
  logic [ENT_W-1:0]  s2_ent_q, s2_ent_d;

  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [ENT_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             capture;
  logic [62:0]      mag;
  logic [5:0]       lz;
  logic [62:0]      shifted;
  logic [SEG_W-1:0] dec_idx;
  logic [OFF_W-1:0] dec_off;

  logic             fifo_empty, fifo_full;
  logic             push, pop, drop;
  logic [ENT_W-1:0] head;

  // Next-state logic for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    wu_cnt_d = wu_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WARMUP;
          wu_cnt_d = '0;
        end
      end
      ST_WARMUP: begin
        wu_cnt_d = wu_cnt_q + 1'b1;
        if (!start)                  state_d = ST_DRAIN;
        else if (wu_cnt_q == WU_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_v_q && !s2_v_q && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    en_taus_d = (state_d == ST_WARMUP) || (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
  end

  // FSM state, warm-up counter and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wu_cnt_q  <= '0;
      en_taus_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wu_cnt_q  <= wu_cnt_d;
      en_taus_q <= en_taus_d;
      busy_q    <= busy_d;
    end
  end

  assign capture = (state_q == ST_RUN);
  assign mag     = s1_w_q[62:0];

  lzc63 u_lzc (
    .din (mag),
    .lz  (lz)
  );

  // Decode: shifting past the leading one leaves the offset bits at the top, zero-filled.
  always_comb begin
    shifted = mag << (7'(lz) + 7'd1);
    if (lz >= SEG_W'(MAX_SEG)) begin
      dec_idx = SEG_W'(MAX_SEG);
      dec_off = '0;
    end else begin
      dec_idx = lz;
      dec_off = shifted[62 -: OFF_W];
    end
    s1_v_d   = capture;
    s1_w_d   = capture ? taus_in : s1_w_q;
    s2_v_d   = s1_v_q;
    s2_ent_d = {s1_w_q[63], dec_idx, dec_off};
  end

  // Capture and decode pipeline; never stalls because the URNG cannot pause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q   <= 1'b0;
      s1_w_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_ent_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_w_q   <= s1_w_d;
      s2_v_q   <= s2_v_d;
      s2_ent_q <= s2_ent_d;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && seg_ready;
  assign push       = s2_v_q && (!fifo_full || pop);
  assign drop       = s2_v_q && fifo_full && !pop;

  // FIFO write, pointer advance and saturating drop counter.
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q[AW-1:0]] = s2_ent_q;
    wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign head      = fifo_q[rd_ptr_q[AW-1:0]];
  assign seg_valid = !fifo_empty;
  assign seg_sign  = head[ENT_W-1];
  assign seg_idx   = head[OFF_W +: SEG_W];
  assign seg_off   = head[OFF_W-1:0];
  assign en_taus   = en_taus_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
